// File: rtl/spi_counter_slave_rx.sv
// Mode-0 SPI slave: receives a 14-bit counter value per 16-bit frame, validates it,
// and returns the last accepted value on miso during the next frame.
module spi_counter_slave_rx #(
   parameter int DATA_W  = 14,
   parameter int FRAME_W = 16,
   parameter int MAX_VAL = 9999
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              cs_n,
   output logic              miso,
   output logic [DATA_W-1:0] count_out,
   output logic              count_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(FRAME_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic               r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic               r_mosi_s1, r_mosi_s2;
   logic               r_cs_s1, r_cs_s2, r_cs_d;
   logic [FRAME_W-1:0] r_tx;
   logic [FRAME_W-1:0] r_rx;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic               r_err;
   logic [DATA_W-1:0]  r_count;
   logic               r_valid;
   logic               r_ferr;
   logic               w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
   logic               w_accept;

   // cs_n synchronizer resets to the idle-high level so reset release does not look like a fall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_d  <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
         r_cs_d    <= 1'b1;
      end else begin
         r_sclk_s1 <= sclk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_d  <= r_sclk_s2;
         r_mosi_s1 <= mosi;
         r_mosi_s2 <= r_mosi_s1;
         r_cs_s1   <= cs_n;
         r_cs_s2   <= r_cs_s1;
         r_cs_d    <= r_cs_s2;
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
   assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
   assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

   assign w_accept = ~r_err
                   && (r_rx[FRAME_W-1:DATA_W] == '0)
                   && (r_rx[DATA_W-1:0] <= DATA_W'(MAX_VAL));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_cs_fall) w_next = S_SHIFT;
         S_SHIFT: begin
            if (w_cs_rise)                              w_next = S_IDLE;
            else if (r_bit_cnt == CNT_W'(FRAME_W))      w_next = S_DONE;
         end
         S_DONE:  if (w_cs_rise) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      miso = 1'b0;
      if (r_state != S_IDLE) begin
         busy = 1'b1;
         miso = r_tx[FRAME_W-1];
      end
   end

   // cs_n rise is handled before any sclk edge seen in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx      <= '0;
         r_rx      <= '0;
         r_bit_cnt <= '0;
         r_err     <= 1'b0;
         r_count   <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  r_tx      <= {{(FRAME_W-DATA_W){1'b0}}, r_count};
                  r_rx      <= '0;
                  r_bit_cnt <= '0;
                  r_err     <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (w_cs_rise) begin
                  r_ferr <= 1'b1;
                  r_rx   <= '0;
               end else begin
                  if (w_sclk_rise) begin
                     r_rx      <= {r_rx[FRAME_W-2:0], r_mosi_s2};
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
                  if (w_sclk_fall) begin
                     r_tx <= {r_tx[FRAME_W-2:0], 1'b0};
                  end
               end
            end
            S_DONE: begin
               if (w_cs_rise) begin
                  if (w_accept) begin
                     r_count <= r_rx[DATA_W-1:0];
                     r_valid <= 1'b1;
                  end else begin
                     r_ferr <= 1'b1;
                  end
               end else if (w_sclk_rise) begin
                  r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign count_out   = r_count;
   assign count_valid = r_valid;
   assign frame_err   = r_ferr;

endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Bench for spi_counter_slave_rx: table of SPI frames with expected results,
// scoreboard queue checked whenever the DUT pulses count_valid or frame_err.
module tb_spi_counter_slave_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        sclk;
   logic        mosi;
   logic        cs_n;
   logic        miso;
   logic [13:0] count_out;
   logic        count_valid;
   logic        frame_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] data;
      int          nbits;
      logic [15:0] exp_miso;
      logic        exp_v;
      logic        exp_e;
      logic [13:0] exp_c;
   } vec_t;

   typedef struct {
      logic        v;
      logic        e;
      logic [13:0] c;
      int          id;
   } exp_t;

   vec_t vecs[10];
   exp_t sb_q[$];
   exp_t mon_e;

   spi_counter_slave_rx #(.DATA_W(14), .FRAME_W(16), .MAX_VAL(9999)) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .mosi        (mosi),
      .cs_n        (cs_n),
      .miso        (miso),
      .count_out   (count_out),
      .count_valid (count_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every output pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst && (count_valid || frame_err)) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got valid=%0b err=%0b, expected none (t=%0t)",
                     count_valid, frame_err, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk($sformatf("count_valid[%0d]", mon_e.id), {31'b0, count_valid}, {31'b0, mon_e.v});
            chk($sformatf("frame_err[%0d]", mon_e.id), {31'b0, frame_err}, {31'b0, mon_e.e});
            chk($sformatf("count_out[%0d]", mon_e.id), {18'b0, count_out}, {18'b0, mon_e.c});
         end
      end
   end

   task automatic send_frame(input int id, input logic [31:0] data, input int nbits,
                             input logic [15:0] exp_miso, input logic ev, input logic ee,
                             input logic [13:0] ec);
      exp_t e;
      cs_n = 1'b0;
      mosi = data[nbits-1];
      clks(4);
      chk($sformatf("busy_hi[%0d]", id), {31'b0, busy}, 32'd1);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         if (i < 16)
            chk($sformatf("miso[%0d].b%0d", id, i), {31'b0, miso}, {31'b0, exp_miso[15-i]});
         clks(4);
         sclk = 1'b0;
         if (i < nbits - 1) mosi = data[nbits-2-i];
         clks(4);
      end
      e.v = ev; e.e = ee; e.c = ec; e.id = id;
      sb_q.push_back(e);
      cs_n = 1'b1;
      clks(4);
      chk($sformatf("busy_lo[%0d]", id), {31'b0, busy}, 32'd0);
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) clks(1);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pulse_timeout[%0d]: got %0d pending, expected 0", id, sb_q.size());
         sb_q.delete();
      end
      clks(4);
   endtask

   initial begin
      vecs[0] = '{32'h04D2,   16, 16'h0000, 1'b1, 1'b0, 14'd1234};
      vecs[1] = '{32'h270F,   16, 16'h04D2, 1'b1, 1'b0, 14'd9999};
      vecs[2] = '{32'h2710,   16, 16'h270F, 1'b0, 1'b1, 14'd9999};
      vecs[3] = '{32'hC001,   16, 16'h270F, 1'b0, 1'b1, 14'd9999};
      vecs[4] = '{32'h0005,   10, 16'h270F, 1'b0, 1'b1, 14'd9999};
      vecs[5] = '{32'h00006,  17, 16'h270F, 1'b0, 1'b1, 14'd9999};
      vecs[6] = '{32'h0005,   16, 16'h270F, 1'b1, 1'b0, 14'd5};
      vecs[7] = '{32'h0000,   16, 16'h0005, 1'b1, 1'b0, 14'd0};
      vecs[8] = '{32'h3FFF,   16, 16'h0000, 1'b0, 1'b1, 14'd0};
      vecs[9] = '{32'h1234,   16, 16'h0000, 1'b1, 1'b0, 14'd4660};

      rst  = 1'b0;
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      clks(3);
      chk("rst_count_out", {18'b0, count_out}, 32'd0);
      chk("rst_count_valid", {31'b0, count_valid}, 32'd0);
      chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_miso", {31'b0, miso}, 32'd0);
      rst = 1'b1;
      clks(5);

      for (int v = 0; v < 10; v++)
         send_frame(v, vecs[v].data, vecs[v].nbits, vecs[v].exp_miso,
                    vecs[v].exp_v, vecs[v].exp_e, vecs[v].exp_c);

      // Reset in the middle of frame 0x1111, after 8 bits
      cs_n = 1'b0;
      mosi = 1'b0;
      clks(4);
      for (int i = 0; i < 8; i++) begin
         mosi = (16'h1111 >> (15 - i)) & 1'b1;
         sclk = 1'b1;
         clks(4);
         sclk = 1'b0;
         clks(4);
      end
      chk("midframe_busy", {31'b0, busy}, 32'd1);
      rst = 1'b0;
      clks(1);
      chk("midrst_count_out", {18'b0, count_out}, 32'd0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_miso", {31'b0, miso}, 32'd0);
      cs_n = 1'b1;
      sclk = 1'b0;
      clks(3);
      rst = 1'b1;
      clks(8);
      chk("postrst_count_out", {18'b0, count_out}, 32'd0);
      chk("postrst_busy", {31'b0, busy}, 32'd0);

      send_frame(10, 32'h0022, 16, 16'h0000, 1'b1, 1'b0, 14'd34);
      chk("final_count_out", {18'b0, count_out}, 32'd34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
